// File: rtl/lfsr_pair_run_ctrl_if.sv
// Config/status bundle between the test/config logic and the dual-LFSR run sequencer.
// The master drives the run request; the slave (sequencer) reports progress and LFSR state.
interface lfsr_pair_run_ctrl_if;
   logic       start;
   logic       abort;
   logic [3:0] seed_a;
   logic [3:0] seed_b;
   logic [7:0] num_steps;
   logic       busy;
   logic       done;
   logic [7:0] even_cnt;
   logic [3:0] a_q;
   logic [3:0] b_q;

   modport master (
      output start,
      output abort,
      output seed_a,
      output seed_b,
      output num_steps,
      input  busy,
      input  done,
      input  even_cnt,
      input  a_q,
      input  b_q
   );

   modport slave (
      input  start,
      input  abort,
      input  seed_a,
      input  seed_b,
      input  num_steps,
      output busy,
      output done,
      output even_cnt,
      output a_q,
      output b_q
   );
endinterface

// File: rtl/lfsr_pair_run_ctrl.sv
// Sequencer for two 4-bit LFSRs: seeds them, steps them N times and counts even sums.
// All outputs come straight from registers or from the state register.
module lfsr_pair_run_ctrl (
   input  logic                 clk,
   input  logic                 rst,
   lfsr_pair_run_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] lfsr_a_q, lfsr_a_d;
   logic [3:0] lfsr_b_q, lfsr_b_d;
   logic [7:0] remaining_q, remaining_d;
   logic [7:0] even_cnt_q, even_cnt_d;
   logic       sum_even;

   function automatic logic [3:0] lfsr_step(input logic [3:0] q);
      return {q[2:0], q[3] ^ q[2]};
   endfunction

   // An all-zero LFSR would lock up, so a zero seed loads 0001 instead.
   function automatic logic [3:0] seed_fix(input logic [3:0] s);
      return (s == 4'd0) ? 4'd1 : s;
   endfunction

   // The LSB of a 4-bit sum depends only on the operand LSBs.
   assign sum_even = ~(lfsr_a_q[0] ^ lfsr_b_q[0]);

   always_comb begin
      state_d     = state_q;
      lfsr_a_d    = lfsr_a_q;
      lfsr_b_d    = lfsr_b_q;
      remaining_d = remaining_q;
      even_cnt_d  = even_cnt_q;

      unique case (state_q)
         StIdle: begin
            // start wins over a simultaneous abort here; abort has no meaning in idle
            if (bus.start) begin
               lfsr_a_d    = seed_fix(bus.seed_a);
               lfsr_b_d    = seed_fix(bus.seed_b);
               remaining_d = bus.num_steps;
               even_cnt_d  = 8'd0;
               state_d     = (bus.num_steps != 8'd0) ? StRun : StDone;
            end
         end

         StRun: begin
            if (bus.abort) begin
               state_d = StIdle;
            end else begin
               if (sum_even) begin
                  even_cnt_d = even_cnt_q + 8'd1;
               end
               lfsr_a_d    = lfsr_step(lfsr_a_q);
               lfsr_b_d    = lfsr_step(lfsr_b_q);
               remaining_d = remaining_q - 8'd1;
               if (remaining_q == 8'd1) begin
                  state_d = StDone;
               end
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         lfsr_a_q    <= 4'd1;
         lfsr_b_q    <= 4'd1;
         remaining_q <= 8'd0;
         even_cnt_q  <= 8'd0;
      end else begin
         state_q     <= state_d;
         lfsr_a_q    <= lfsr_a_d;
         lfsr_b_q    <= lfsr_b_d;
         remaining_q <= remaining_d;
         even_cnt_q  <= even_cnt_d;
      end
   end

   assign bus.busy     = (state_q != StIdle);
   assign bus.done     = (state_q == StDone);
   assign bus.even_cnt = even_cnt_q;
   assign bus.a_q      = lfsr_a_q;
   assign bus.b_q      = lfsr_b_q;

endmodule
